// File: rtl/ppu_pkg.sv
// Shared constants for the PPU layer mixer: default geometry, transparency key
// and the register map of the Avalon write bus.
package ppu_pkg;
    localparam int COLOR_W    = 24;
    localparam int NUM_LAYERS = 20;
    localparam int H_VISIBLE  = 640;
    localparam int V_VISIBLE  = 480;

    localparam logic [23:0] TRANSPARENT_KEY = 24'h202020;

    localparam logic [2:0] ADDR_BG   = 3'd0;
    localparam logic [2:0] ADDR_EN   = 3'd1;
    localparam logic [2:0] ADDR_TKEY = 3'd2;
    localparam logic [2:0] ADDR_PAIR = 3'd3;
    localparam logic [2:0] ADDR_CLR  = 3'd4;
endpackage

// File: rtl/ppu_layer_mixer_if.sv
// Avalon-style register write bus shared with the display units.
interface ppu_layer_mixer_if;
    logic        write;
    logic [2:0]  address;
    logic [31:0] writedata;

    modport master (output write, output address, output writedata);
    modport slave  (input  write, input  address, input  writedata);
endinterface

// File: rtl/ppu_priority_select.sv
// First-set-bit encoder: bit 0 of the mask has the highest priority.
module ppu_priority_select
    import ppu_pkg::*;
#(
    parameter int NUM_LAYERS = 20,
    parameter int IDX_W      = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
    input  logic [NUM_LAYERS-1:0] mask,
    output logic                  found,
    output logic [IDX_W-1:0]      index
);
    always_comb begin
        found = 1'b0;
        index = '0;
        // Walking downwards lets the lowest set bit overwrite the others.
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (mask[i]) begin
                found = 1'b1;
                index = IDX_W'(i);
            end
        end
    end
endmodule

// File: rtl/ppu_layer_mixer.sv
// Two-stage layer compositor: stage 1 keys and registers the layers, stage 2
// picks the winning colour; also tracks per-frame collision of two layers.
module ppu_layer_mixer
    import ppu_pkg::*;
#(
    parameter int NUM_LAYERS = ppu_pkg::NUM_LAYERS,
    parameter int COLOR_W    = ppu_pkg::COLOR_W,
    parameter int H_VISIBLE  = ppu_pkg::H_VISIBLE,
    parameter int V_VISIBLE  = ppu_pkg::V_VISIBLE
) (
    input  logic                          clk,
    input  logic                          reset,
    ppu_layer_mixer_if.slave              bus,
    input  logic [9:0]                    hcount,
    input  logic [9:0]                    vcount,
    input  logic [NUM_LAYERS*COLOR_W-1:0] layer_rgb,
    output logic [COLOR_W-1:0]            RGB_output,
    output logic                          collision,
    output logic                          collision_irq
);
    localparam int IDX_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;

    typedef logic [COLOR_W-1:0] color_t;

    color_t                              bg_color_q, bg_color_d;
    color_t                              tkey_q, tkey_d;
    logic [NUM_LAYERS-1:0]               layer_en_q, layer_en_d;
    logic [4:0]                          pair_a_q, pair_a_d, pair_b_q, pair_b_d;
    logic                                clr_req;
    logic [NUM_LAYERS-1:0]               opaque_q, opaque_d;
    logic [NUM_LAYERS-1:0][COLOR_W-1:0]  rgb_q;
    logic                                visible_q, visible_d;
    logic                                frame_end_q, frame_end_d;
    color_t                              rgb_out_q, rgb_out_d;
    logic                                collision_q, collision_d;
    logic                                irq_q, irq_d;
    logic                                acc_q, acc_d;
    logic                                sel_found;
    logic [IDX_W-1:0]                    sel_idx;
    logic                                pair_hit;
    logic                                unused_wdata;

    assign unused_wdata = &{1'b0, bus.writedata};

    function automatic logic mask_bit(input logic [NUM_LAYERS-1:0] mask,
                                      input logic [4:0] idx);
        mask_bit = 1'b0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            if (idx == 5'(i)) mask_bit = mask[i];
        end
    endfunction

    always_comb begin
        bg_color_d = bg_color_q;
        layer_en_d = layer_en_q;
        tkey_d     = tkey_q;
        pair_a_d   = pair_a_q;
        pair_b_d   = pair_b_q;
        clr_req    = 1'b0;
        if (bus.write) begin
            case (bus.address)
                ADDR_BG:   bg_color_d = bus.writedata[COLOR_W-1:0];
                ADDR_EN:   layer_en_d = bus.writedata[NUM_LAYERS-1:0];
                ADDR_TKEY: tkey_d     = bus.writedata[COLOR_W-1:0];
                ADDR_PAIR: begin
                    pair_a_d = bus.writedata[4:0];
                    pair_b_d = bus.writedata[12:8];
                end
                ADDR_CLR:  clr_req    = bus.writedata[0];
                default:   ;
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_LAYERS; gi++) begin : g_opaque
            assign opaque_d[gi] = layer_en_q[gi] &&
                                  (layer_rgb[gi*COLOR_W +: COLOR_W] != tkey_q);
        end
    endgenerate

    assign visible_d   = (hcount < 10'(H_VISIBLE)) && (vcount < 10'(V_VISIBLE));
    assign frame_end_d = (hcount == 10'd0) && (vcount == 10'(V_VISIBLE));

    ppu_priority_select #(
        .NUM_LAYERS (NUM_LAYERS),
        .IDX_W      (IDX_W)
    ) u_select (
        .mask  (opaque_q),
        .found (sel_found),
        .index (sel_idx)
    );

    // Out-of-range pair indices never match because mask_bit returns 0 for them.
    assign pair_hit = visible_q && mask_bit(opaque_q, pair_a_q) && mask_bit(opaque_q, pair_b_q);

    always_comb begin
        rgb_out_d = '0;
        if (visible_q) rgb_out_d = sel_found ? rgb_q[sel_idx] : bg_color_q;

        acc_d       = acc_q | pair_hit;
        collision_d = collision_q;
        irq_d       = 1'b0;
        // Frame end takes precedence over a clear written in the same cycle.
        if (frame_end_q) begin
            collision_d = acc_q;
            irq_d       = acc_q;
            acc_d       = 1'b0;
        end else if (clr_req) begin
            collision_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bg_color_q  <= '0;
            layer_en_q  <= '1;
            tkey_q      <= COLOR_W'(TRANSPARENT_KEY);
            pair_a_q    <= 5'd3;
            pair_b_q    <= 5'd5;
            opaque_q    <= '0;
            rgb_q       <= '0;
            visible_q   <= 1'b0;
            frame_end_q <= 1'b0;
            rgb_out_q   <= '0;
            collision_q <= 1'b0;
            irq_q       <= 1'b0;
            acc_q       <= 1'b0;
        end else begin
            bg_color_q  <= bg_color_d;
            layer_en_q  <= layer_en_d;
            tkey_q      <= tkey_d;
            pair_a_q    <= pair_a_d;
            pair_b_q    <= pair_b_d;
            opaque_q    <= opaque_d;
            rgb_q       <= layer_rgb;
            visible_q   <= visible_d;
            frame_end_q <= frame_end_d;
            rgb_out_q   <= rgb_out_d;
            collision_q <= collision_d;
            irq_q       <= irq_d;
            acc_q       <= acc_d;
        end
    end

    assign RGB_output    = rgb_out_q;
    assign collision     = collision_q;
    assign collision_irq = irq_q;
endmodule

// File: tb/tb_ppu_layer_mixer.sv
// Directed bench for ppu_layer_mixer: pixel expectations go through a scoreboard
// queue and are checked when they emerge two clocks later.
module tb_ppu_layer_mixer;
    import ppu_pkg::*;

    localparam logic [23:0] KEY = 24'h202020;

    typedef struct {
        bit          chk;
        logic [23:0] rgb;
        string       tag;
    } exp_t;

    logic               clk = 1'b0;
    logic               reset;
    logic [9:0]         hc, vc;
    logic [19:0][23:0]  layers;
    logic [23:0]        rgb_out;
    logic               coll, irq;
    exp_t               sb[$];
    int                 n_cmp = 0;
    int                 n_err = 0;

    always #5 clk = ~clk;

    ppu_layer_mixer_if bus_if ();

    ppu_layer_mixer #(
        .NUM_LAYERS (20),
        .COLOR_W    (24),
        .H_VISIBLE  (640),
        .V_VISIBLE  (480)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .bus           (bus_if),
        .hcount        (hc),
        .vcount        (vc),
        .layer_rgb     (layers),
        .RGB_output    (rgb_out),
        .collision     (coll),
        .collision_irq (irq)
    );

    task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        n_cmp++;
        $display("[%0t] %s observed=%h expected=%h", $time, tag, obs, exp);
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One pixel per call: queue its expectation, clock, then check the pixel
    // pushed on the previous call, which has just reached RGB_output.
    task automatic tick(input bit chk, input logic [23:0] e, input string tag);
        exp_t it;
        it.chk = chk;
        it.rgb = e;
        it.tag = tag;
        sb.push_back(it);
        @(posedge clk);
        #1;
        if (sb.size() > 1) begin
            it = sb.pop_front();
            if (it.chk) check(it.tag, rgb_out, it.rgb);
        end
    endtask

    task automatic wr(input logic [2:0] addr, input logic [31:0] data);
        bus_if.write     = 1'b1;
        bus_if.address   = addr;
        bus_if.writedata = data;
        tick(1'b0, 24'h0, "wr");
        bus_if.write     = 1'b0;
    endtask

    task automatic set_all(input logic [23:0] c);
        for (int i = 0; i < 20; i++) layers[i] = c;
    endtask

    // Frame-end pixel, then verify collision/irq two clocks on and irq dropping after.
    task automatic frame_end(input string tag, input logic exp_coll);
        hc = 10'd0;
        vc = 10'd480;
        tick(1'b1, 24'h0, {tag, "_fe_px"});
        check({tag, "_irq_early"}, {23'h0, irq}, 24'h0);
        hc = 10'd1;
        tick(1'b1, 24'h0, {tag, "_post_px"});
        check({tag, "_coll"}, {23'h0, coll}, {23'h0, exp_coll});
        check({tag, "_irq"},  {23'h0, irq},  {23'h0, exp_coll});
        tick(1'b0, 24'h0, "idle");
        check({tag, "_irq_drop"}, {23'h0, irq}, 24'h0);
        check({tag, "_coll_hold"}, {23'h0, coll}, {23'h0, exp_coll});
    endtask

    initial begin
        bus_if.write     = 1'b0;
        bus_if.address   = 3'd0;
        bus_if.writedata = 32'h0;
        hc     = 10'd10;
        vc     = 10'd10;
        set_all(KEY);
        reset  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_rgb",  rgb_out, 24'h0);
        check("reset_coll", {23'h0, coll}, 24'h0);
        check("reset_irq",  {23'h0, irq},  24'h0);
        reset = 1'b0;

        // Background after reset, then programmed background.
        tick(1'b1, 24'h000000, "bg_reset");
        tick(1'b1, 24'h000000, "bg_reset2");
        wr(ADDR_BG, 32'h005C94FC);
        tick(1'b1, 24'h5C94FC, "bg_set");

        // Priority and layer enable.
        layers[3] = 24'hFF0000;
        layers[5] = 24'h00FF00;
        tick(1'b1, 24'hFF0000, "prio_l3");
        wr(ADDR_EN, 32'h000FFFF7);
        tick(1'b1, 24'h00FF00, "en_l3_off");
        wr(ADDR_EN, 32'h000FFFFF);
        tick(1'b1, 24'hFF0000, "en_l3_on");

        // Programmable transparency key.
        set_all(24'h000000);
        layers[3] = 24'hFF0000;
        wr(ADDR_TKEY, 32'h00000000);
        layers[0] = 24'h202020;
        tick(1'b1, 24'h202020, "tkey_l0_opaque");
        layers[0] = 24'h000000;
        tick(1'b1, 24'hFF0000, "tkey_l0_keyed");
        set_all(KEY);
        wr(ADDR_TKEY, {8'h0, KEY});
        tick(1'b1, 24'h5C94FC, "tkey_restored");

        // Flush collisions accumulated above, then clear the latched flag.
        frame_end("flush", 1'b1);
        wr(ADDR_CLR, 32'h1);
        check("clear_coll", {23'h0, coll}, 24'h0);

        // Overlap of layers 3 and 5 on a single pixel.
        hc = 10'd100; vc = 10'd200;
        layers[3] = 24'hFF0000;
        layers[5] = 24'h00FF00;
        tick(1'b1, 24'hFF0000, "ovl_px");
        set_all(KEY);
        hc = 10'd101;
        tick(1'b1, 24'h5C94FC, "ovl_next");
        tick(1'b1, 24'h5C94FC, "ovl_next2");
        check("coll_midframe", {23'h0, coll}, 24'h0);
        frame_end("ovl", 1'b1);

        // Next frame without overlap.
        hc = 10'd100; vc = 10'd200;
        layers[3] = 24'hFF0000;
        tick(1'b1, 24'hFF0000, "single_px");
        set_all(KEY);
        frame_end("noovl", 1'b0);

        // Overlap outside the visible area is ignored.
        hc = 10'd640; vc = 10'd10;
        layers[3] = 24'hFF0000;
        layers[5] = 24'h00FF00;
        tick(1'b1, 24'h000000, "offscreen_px");
        set_all(KEY);
        frame_end("offscreen", 1'b0);

        // Pair index beyond the layer count never matches.
        wr(ADDR_PAIR, 32'h0000051F);
        hc = 10'd100; vc = 10'd100;
        for (int i = 0; i < 20; i++) layers[i] = 24'h010000 + 24'(i);
        tick(1'b1, 24'h010000, "pair31_px");
        set_all(KEY);
        frame_end("pair31", 1'b0);

        // pair_a == pair_b collides whenever that layer is opaque.
        wr(ADDR_PAIR, 32'h00000303);
        hc = 10'd50; vc = 10'd50;
        layers[3] = 24'hFF0000;
        tick(1'b1, 24'hFF0000, "pair33_px");
        set_all(KEY);
        frame_end("pair33", 1'b1);
        wr(ADDR_CLR, 32'h1);
        check("clear_coll2", {23'h0, coll}, 24'h0);

        // Reset mid-line with a collision pending and registers modified.
        wr(ADDR_PAIR, 32'h00000503);
        hc = 10'd300; vc = 10'd20;
        layers[3] = 24'hFF0000;
        layers[5] = 24'h00FF00;
        tick(1'b1, 24'hFF0000, "pre_rst_px");
        set_all(KEY);
        wr(ADDR_BG, 32'h00123456);
        wr(ADDR_EN, 32'h00000000);
        wr(ADDR_TKEY, 32'h00000000);
        hc = 10'd305;
        tick(1'b0, 24'h0, "fill");
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_rgb",  rgb_out, 24'h0);
        check("midrst_coll", {23'h0, coll}, 24'h0);
        sb.delete();
        reset = 1'b0;
        hc = 10'd10; vc = 10'd10;
        tick(1'b1, 24'h000000, "post_rst_bg");
        tick(1'b1, 24'h000000, "post_rst_bg2");
        layers[3] = 24'hFF0000;
        tick(1'b1, 24'hFF0000, "post_rst_en");
        set_all(KEY);
        tick(1'b1, 24'h000000, "post_rst_key");
        frame_end("post_rst", 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
